// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath. It steps each instruction through
// fetch, decode, execute, memory and write-back, and decodes every datapath control line
// from the current state.
module mips_multicycle_ctrl (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExec   = 4'd6,
        StRwb    = 4'd7,
        StBranch = 4'd8,
        StJump   = 4'd9,
        StAddiEx = 4'd10,
        StAddiWb = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    // State and illegal-opcode pulse registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; Op is consulted only in DECODE and MEMADR.
    always_comb begin
        state_d   = StFetch;
        illegal_d = 1'b0;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (Op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExec;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi:     state_d = StAddiEx;
                    default: begin
                        state_d   = StFetch;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                if (Op == OpLw) begin
                    state_d = StMemRd;
                end else if (Op == OpSw) begin
                    state_d = StMemWr;
                end else begin
                    // Op is no longer a memory opcode: drop the instruction.
                    state_d = StFetch;
                end
            end
            StMemRd:  state_d = StMemWb;
            StExec:   state_d = StRwb;
            StAddiEx: state_d = StAddiWb;
            // MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB and unused codes return to FETCH.
            default:  state_d = StFetch;
        endcase
    end

    // Moore output decode; every control line is held low while reset is asserted.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        if (!RST) begin
            case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                end
                StDecode: ALUSrcB = 2'b11;
                StMemAdr, StAddiEx: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                StMemRd: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                StMemWr: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StExec: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                StRwb: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                StBranch: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                StJump: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                StAddiWb: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign Illegal = illegal_q & ~RST;
    assign State   = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: per-cycle vector table plus cycle-count sequences.
module tb_mips_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Op  = 6'b000000;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    mips_multicycle_ctrl dut (
        .CLK         (CLK),
        .RST         (RST),
        .Op          (Op),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .Illegal     (Illegal),
        .State       (State)
    );

    always #5 CLK = ~CLK;

    // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
    //  RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource}
    logic [15:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    localparam logic [15:0] CZero   = 16'b0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] CFetch  = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
    localparam logic [15:0] CDecode = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [15:0] CMemAdr = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [15:0] CMemRd  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
    localparam logic [15:0] CMemWb  = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [15:0] CMemWr  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [15:0] CExec   = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
    localparam logic [15:0] CRwb    = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [15:0] CBranch = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [15:0] CJump   = 16'b1_0_0_0_0_0_0_0_0_0_00_00_10;
    localparam logic [15:0] CAddiEx = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [15:0] CAddiWb = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;

    localparam logic [5:0] OR  = 6'b000000;
    localparam logic [5:0] OLw = 6'b100011;
    localparam logic [5:0] OSw = 6'b101011;
    localparam logic [5:0] OBq = 6'b000100;
    localparam logic [5:0] OJ  = 6'b000010;
    localparam logic [5:0] OAd = 6'b001000;
    localparam logic [5:0] OIl = 6'b111111;

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic [5:0] op, input logic [3:0] st,
                       input logic [15:0] c, input logic ill);
        vec_t v;
        v.rst  = rst;
        v.op   = op;
        v.st   = st;
        v.ctrl = c;
        v.ill  = ill;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starting mid-FETCH, run one instruction and count edges until FETCH again.
    task automatic run_cpi(input string name, input logic [5:0] op, input int exp_cycles,
                           input logic is_illegal);
        int cycles     = 0;
        int ill_cycles = 0;
        logic strobe   = 1'b0;
        Op = op;
        do begin
            @(posedge CLK);
            #1;
            cycles++;
            if (Illegal === 1'b1) ill_cycles++;
            if (is_illegal && (MemWrite !== 1'b0 || RegWrite !== 1'b0 ||
                               PCWriteCond !== 1'b0)) strobe = 1'b1;
        end while (State !== 4'd0 && cycles < 20);
        check({name, " cpi"}, cycles, exp_cycles);
        if (is_illegal) begin
            check({name, " illegal at refetch"}, {31'd0, Illegal}, 32'd1);
            check({name, " no write strobe"}, {31'd0, strobe}, 32'd0);
            @(posedge CLK);
            #1;
            if (Illegal === 1'b1) ill_cycles++;
            check({name, " illegal one cycle"}, ill_cycles, 1);
            // Back in DECODE; give it a legal Op and let jump finish to re-align to FETCH.
            Op = OJ;
            repeat (2) @(posedge CLK);
            #1;
            check({name, " realign fetch"}, {28'd0, State}, 32'd0);
        end else begin
            check({name, " no illegal"}, ill_cycles, 0);
        end
    endtask

    initial begin
        // Per-cycle vectors: inputs applied for the cycle, outputs expected within it.
        add(1, OR,  0,  CZero,   0);
        add(0, OLw, 0,  CFetch,  0);
        add(0, OLw, 1,  CDecode, 0);
        add(0, OLw, 2,  CMemAdr, 0);
        add(0, OLw, 3,  CMemRd,  0);
        add(0, OLw, 4,  CMemWb,  0);
        add(0, OSw, 0,  CFetch,  0);
        add(0, OSw, 1,  CDecode, 0);
        add(0, OSw, 2,  CMemAdr, 0);
        add(0, OSw, 5,  CMemWr,  0);
        add(0, OR,  0,  CFetch,  0);
        add(0, OR,  1,  CDecode, 0);
        add(0, OR,  6,  CExec,   0);
        add(0, OR,  7,  CRwb,    0);
        add(0, OAd, 0,  CFetch,  0);
        add(0, OAd, 1,  CDecode, 0);
        add(0, OAd, 10, CAddiEx, 0);
        add(0, OAd, 11, CAddiWb, 0);
        add(0, OBq, 0,  CFetch,  0);
        add(0, OBq, 1,  CDecode, 0);
        add(0, OBq, 8,  CBranch, 0);
        add(0, OJ,  0,  CFetch,  0);
        add(0, OJ,  1,  CDecode, 0);
        add(0, OJ,  9,  CJump,   0);
        add(0, OIl, 0,  CFetch,  0);
        add(0, OIl, 1,  CDecode, 0);
        add(0, OLw, 0,  CFetch,  1);
        add(0, OSw, 1,  CDecode, 0);
        add(0, OSw, 2,  CMemAdr, 0);
        add(1, OSw, 5,  CZero,   0);
        add(0, OR,  0,  CFetch,  0);
        add(0, OR,  1,  CDecode, 0);
        add(0, OJ,  6,  CExec,   0);
        add(0, OSw, 7,  CRwb,    0);
        add(0, OBq, 0,  CFetch,  0);
        add(0, OBq, 1,  CDecode, 0);
        add(0, OJ,  8,  CBranch, 0);
        add(0, OJ,  0,  CFetch,  0);

        RST = 1'b1;
        repeat (2) @(posedge CLK);

        foreach (vecs[i]) begin
            @(negedge CLK);
            RST = vecs[i].rst;
            Op  = vecs[i].op;
            #1;
            check($sformatf("row %0d state", i), {28'd0, State}, {28'd0, vecs[i].st});
            check($sformatf("row %0d ctrl", i), {16'd0, ctrl}, {16'd0, vecs[i].ctrl});
            check($sformatf("row %0d illegal", i), {31'd0, Illegal}, {31'd0, vecs[i].ill});
        end

        // Now mid-FETCH: cycle counts per instruction class.
        run_cpi("j",     OJ,  3, 1'b0);
        run_cpi("lw",    OLw, 5, 1'b0);
        run_cpi("sw",    OSw, 4, 1'b0);
        run_cpi("rtype", OR,  4, 1'b0);
        run_cpi("addi",  OAd, 4, 1'b0);
        run_cpi("beq",   OBq, 3, 1'b0);
        run_cpi("ill",   OIl, 2, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and write-back cycles, and drives every datapath control line from its current state. PCWrite, PCWriteCond and the ALU's Zero feed the downstream PC-enable gate network (AND/OR primitives): PCEn = PCWrite | (PCWriteCond & Zero). That gate network is not part of this block.

## Interface
Parameters:
- none (opcode encodings fixed: R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, j 6'b000010, addi 6'b001000)

Ports:
- CLK  input  1  single clock; all state changes on the rising edge
- RST  input  1  synchronous, active-high reset
- Op  input  6  opcode field, IR[31:26], valid from DECODE onward
- PCWrite  output  1  unconditional PC write
- PCWriteCond  output  1  conditional PC write (branch)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  output  1 each  memory strobes
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst  output  1  write register: 0 = rt, 1 = rd
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = signext, 11 = signext<<2
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded
- PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target
- Illegal  output  1  one-cycle pulse on an unsupported opcode
- State  output  4  current state, for debug and verification

## Operation
- Moore machine: every output is a combinational decode of State only. Illegal is the exception; it is a registered pulse.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11. Codes 12–15 are unused.
- FETCH: MemRead, IRWrite, PCWrite, ALUSrcB = 01. Next state is DECODE.
- DECODE: ALUSrcB = 11. Next state is chosen by Op:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - any other Op → FETCH, with Illegal = 1 during the following cycle
- MEMADR: ALUSrcA = 1, ALUSrcB = 10. lw → MEMRD; sw → MEMWR.
- MEMRD: MemRead, IorD → MEMWB. MEMWB: RegWrite, MemtoReg → FETCH.
- MEMWR: MemWrite, IorD → FETCH.
- EXEC: ALUSrcA = 1, ALUOp = 10 → RWB. RWB: RegWrite, RegDst → FETCH.
- BRANCH: ALUSrcA = 1, ALUOp = 01, PCWriteCond, PCSource = 01 → FETCH.
- JUMP: PCWrite, PCSource = 10 → FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10 → ADDIWB. ADDIWB: RegWrite → FETCH.
- Any output not listed for a state is 0 in that state.
- Unused state codes 12–15 decode to all outputs 0 and go to FETCH on the next edge.
- Op is sampled only in DECODE and MEMADR. Op changes in any other state have no effect.

## Timing
- Reset: RST = 1 at a rising edge sets State = FETCH (0) and Illegal = 0.
- While RST = 1, all control outputs are forced to 0 combinationally. State still reads 0 once the reset edge has occurred.
- First FETCH outputs appear in the cycle after RST deasserts.
- Cycles per instruction, counted FETCH to return-to-FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- RST asserted mid-instruction aborts it. Next state is FETCH and no write strobe is asserted in the reset cycle.
- Illegal is high for exactly one cycle, coincident with the FETCH that follows the offending DECODE.

## Test plan
- Reset: hold RST = 1 for 2 cycles → State = 0 and all outputs 0 while RST = 1. First cycle after release: MemRead = IRWrite = PCWrite = 1, ALUSrcB = 01.
- lw (Op = 100011) → State sequence 0, 1, 2, 3, 4, 0. MEMRD has MemRead = IorD = 1. MEMWB has RegWrite = MemtoReg = 1.
- sw, then R-type, then addi, back to back → State sequences 0,1,2,5 / 0,1,6,7 / 0,1,10,11. MemWrite is asserted only in state 5. RegDst = 1 only in state 7.
- beq (Op = 000100) and j (Op = 000010) → BRANCH has PCWriteCond = 1, ALUOp = 01, PCSource = 01. JUMP has PCWrite = 1, PCSource = 10. Each instruction takes 3 cycles.
- Illegal Op = 111111 → State 0, 1, 0. Illegal = 1 for one cycle and no write strobe is asserted.
- RST = 1 while State = 5 (MEMWR) → MemWrite drops to 0 immediately and State = 0 at the next edge.
